// File: rtl/data_mem_responder_if.sv
// Load/store request and response bundle between the memory stage
// and the data-memory responder.
interface data_mem_responder_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mem_ready;
    logic        addr_err;
    logic        stall;

    modport master (
        output mem_r_en, mem_w_en, addr, wdata,
        input  rdata, mem_ready, addr_err, stall
    );

    modport slave (
        input  mem_r_en, mem_w_en, addr, wdata,
        output rdata, mem_ready, addr_err, stall
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory: captures one load/store, waits LATENCY
// cycles, performs it, then pulses mem_ready for one cycle.
module data_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input logic clk,
    input logic rst,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_op_w;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic          w_req;
    logic          w_legal;
    logic [AW-1:0] w_idx;

    assign w_req   = bus.mem_r_en | bus.mem_w_en;
    assign w_legal = (r_addr[1:0] == 2'b00) &&
                     (r_addr < 32'(4 * DEPTH));
    assign w_idx   = r_addr[AW+1:2];

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_req) w_next = S_BUSY;
            S_BUSY:  if (r_cnt == 4'd0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_op_w  <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        // write wins when both enables are high
                        r_op_w  <= bus.mem_w_en;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_cnt   <= 4'(LATENCY - 1);
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_err <= ~w_legal;
                        if (r_op_w) begin
                            if (w_legal) r_mem[w_idx] <= r_wdata;
                        end else begin
                            r_rdata <= w_legal ? r_mem[w_idx] : 32'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rdata     = r_rdata;
    assign bus.mem_ready = (r_state == S_DONE);
    assign bus.addr_err  = (r_state == S_DONE) & r_err;
    assign bus.stall     = ((r_state == S_IDLE) & w_req) |
                           (r_state == S_BUSY);
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder serving load/store requests issued by the pipeline's memory stage. Accepts one read or write per transaction and completes it after a fixed programmable latency. Holds the pipeline with `stall` until completion and signals completion with a one-cycle `mem_ready` pulse. Replaces the zero-latency data memory so the core can be exercised against realistic memory timing.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words; power of two, ≥ 4.
- `LATENCY`, 2: wait cycles before the access is performed; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `mem_r_en`  in  1  load request from the memory stage.
- `mem_w_en`  in  1  store request from the memory stage.
- `addr`  in  32  byte address (the ALU result).
- `wdata`  in  32  store data.
- `rdata`  out  32  load data, registered.
- `mem_ready`  out  1  one-cycle completion pulse.
- `addr_err`  out  1  asserted together with `mem_ready` when the completed access was illegal.
- `stall`  out  1  freeze request to the pipeline; combinational.

## Operation
- States: IDLE, BUSY, DONE; 4-bit down-counter `cnt`; capture registers for op, addr, and wdata.
- IDLE:
  - If `mem_r_en | mem_w_en`, capture the op, `addr`, and `wdata`, set `cnt = LATENCY-1`, and go to BUSY.
  - If both enables are high, the op is a write; the read is dropped.
- BUSY:
  - If `cnt != 0`, decrement.
  - If `cnt == 0`, perform the access using the captured values, then go to DONE.
  - Input changes during BUSY are ignored.
- Access legality: the access is illegal if `addr[1:0] != 0` or `addr >= 4*DEPTH`.
  - An illegal access writes nothing, sets `rdata` to 0 (for reads), and raises `addr_err` in DONE.
- Legal access:
  - Word index is `addr[log2(DEPTH)+1:2]`.
  - A write updates the array; `rdata` is unchanged.
  - A read loads `rdata` with the array word.
- DONE: `mem_ready = 1`, `stall = 0`, go to IDLE unconditionally. Enables seen during DONE are ignored; they belong to the instruction that is leaving.
- `stall = (state==IDLE & (mem_r_en|mem_w_en)) | state==BUSY`.
- `rdata` holds its value until the next legal or illegal read completes.
- Reset:
  - State goes to IDLE; `cnt`, `rdata`, `mem_ready`, and `addr_err` go to 0.
  - All DEPTH words are cleared to 0.
  - `stall` is 0 whenever the enables are low.
- Reset mid-transaction aborts the transaction; a pending write is not performed.

## Timing
- A request first seen in IDLE at cycle 0:
  - Access is performed at the edge ending cycle LATENCY.
  - DONE (`mem_ready = 1`, new `rdata` visible) occurs in cycle LATENCY+1.
- `stall` is high for cycles 0..LATENCY, which is LATENCY+1 cycles, and low in DONE.
- Back-to-back requests: the earliest next acceptance is cycle LATENCY+2 (IDLE). Throughput is one access per LATENCY+2 cycles.
- The pipeline must hold the enables, `addr`, and `wdata` stable while `stall` is high. Only the cycle-0 values are used.
- `mem_ready` and `addr_err` are never high outside DONE. They are registered-state decodes with no combinational path from the inputs.

## Test plan
- Reset: hold `rst = 0` for 2 cycles with `mem_r_en = 1`.
  - Required: `rdata = 0`, `mem_ready = 0`, `addr_err = 0`, and no transaction starts.
  - After release, a read of address 0x0 returns 0.
- Store then load, LATENCY=2:
  - Write 0xDEADBEEF to 0x10: `stall` is high for cycles 0–2 and `mem_ready` pulses in cycle 3.
  - Read 0x10 starting in cycle 4: `rdata = 0xDEADBEEF` with `mem_ready` in cycle 7.
- Illegal access:
  - Read 0x13: `addr_err = 1` and `rdata = 0` in DONE.
  - Write 0x100 with DEPTH=64: `addr_err = 1`, and a read of 0x0 afterwards is still 0.
- Simultaneous enables: `mem_r_en = mem_w_en = 1`, addr 0x8, wdata 0x5A5A5A5A.
  - Required: a write is performed and `rdata` is unchanged.
  - A subsequent read of 0x8 returns 0x5A5A5A5A.
- Input changes during BUSY: change `addr` to 0x20 and `wdata` to 0x1 in cycle 1 of a write to 0x4 with value 0x77.
  - Required: 0x4 holds 0x77 and 0x20 is still 0.
- Reset during BUSY: assert `rst = 0` in cycle 1 of a write of 0x99 to 0xC.
  - Required: IDLE on the next edge with `stall = 0`, and a later read of 0xC returns 0.
